uart_pull_tx: RTL and testbench
===============================

# uart_pull_tx

Serial transmitter that pulls words from an upstream sequential source and sends them as 8N1-style asynchronous frames on a single line. It sits directly downstream of the pull-style ROM/FIFO sources in the test designs: it drives their `get` strobe and consumes their registered `out`/`empty` outputs. It is self-pacing, with no external start or valid signal, and sends until the source reports empty.

## Interface

Parameters:
- `W`, default 8: data bits per frame; matches the source word width.
- `DIV`, default 16: clock cycles per serial bit; must be ≥ 2.

Ports:
- `reset`, input, 1: synchronous, active-high.
- `clock`, input, 1: all state changes on the rising edge.
- `get`, output, 1: pull strobe to the source, combinational.
- `data`, input, W: source word; valid in the cycle after `get`.
- `empty`, input, 1: source has no more words.
- `tx`, output, 1: serial line, registered, idle high.
- `busy`, output, 1: high whenever state ≠ IDLE, registered.

## Operation

- Frame format: 1 start bit (0), then W data bits LSB first, then 1 stop bit (1). Each bit lasts exactly DIV cycles.
- States:
  - IDLE: `get = !reset & !empty`. If `get`, next state is FETCH; otherwise stay in IDLE.
  - FETCH: source `out` has updated. At this edge: `shift <= data`, `tx <= 0`, `cnt <= DIV-1`, next state START.
  - START: count `cnt` down. At `cnt == 0`: `tx <= shift[0]`, `shift >>= 1`, `bit <= 0`, `cnt <= DIV-1`, next state DATA.
  - DATA: at `cnt == 0`:
    - If `bit == W-1`: `tx <= 1`, next state STOP.
    - Otherwise: `tx <= shift[0]`, shift right, `bit <= bit + 1`.
    - In both cases reload `cnt <= DIV-1`.
  - STOP: at `cnt == 0`, next state IDLE; `tx` stays 1.
- `get` is asserted only in IDLE, for exactly one cycle per word, never while `empty` = 1 and never during reset.
- `data` is sampled only in FETCH. It is ignored in every other state, and the source holds it anyway.
- Counter widths: `cnt` is `$clog2(DIV)` bits, `bit` is `$clog2(W)` bits (minimum 1). No wrap: both counters are reloaded before they would underflow.
- `empty` changing during a frame has no effect. It is examined only in IDLE.
- The source reaches empty after its last `get`. The frame in flight completes, then the block stays in IDLE with `tx` = 1.

## Timing

- Reset values: `tx` = 1, `busy` = 0, `get` = 0, state IDLE, `cnt` = 0, `bit` = 0, `shift` = 0.
- Reset mid-frame: on the next cycle `tx` = 1 and `busy` = 0. The partial frame is truncated and the word is lost. The source shares `reset` and rewinds too.
- Let `get` be high in cycle t:
  - `tx` falls at cycle t+2.
  - Data bit i is on `tx` during cycles t+2+(i+1)·DIV through t+1+(i+2)·DIV.
  - The stop bit starts at cycle t+2+(W+1)·DIV.
  - The block re-enters IDLE at cycle t+2+(W+2)·DIV.
- `busy` is high from t+1 through t+1+(W+2)·DIV inclusive.
- Back-to-back words: the next `get` falls in the IDLE cycle t+2+(W+2)·DIV. Frame period is (W+2)·DIV + 2 cycles, and `tx` stays high for 2 extra cycles between frames.
- Throughput: one word per (W+2)·DIV + 2 cycles. Latency from `get` to start edge: 2 cycles.

## Test plan

- Reset, with `empty` = 1 held, W=8, DIV=4 → `tx` = 1, `busy` = 0, `get` = 0 on every cycle for 100 cycles.
- Single word 0x48, DIV=4:
  - `get` pulse at t.
  - `tx` is 0 over t+2..t+5.
  - Data bits then follow in 4-cycle slots: 0,0,0,1,0,0,1,0.
  - Stop: `tx` = 1 over t+38..t+41.
  - `busy` falls at t+42.
- Back-to-back 0x55 then 0xA3 from a 2-word source model, DIV=4 → second `get` exactly at t+42, second start edge at t+44, both frames bit-exact, `empty` seen after the 2nd `get` → no third `get`.
- 7-word ROM source, DIV=2 → exactly 7 `get` pulses, spaced 22 cycles apart. A receiver model decodes the 7 bytes in order, then `tx` stays high.
- Reset asserted for 1 cycle mid-DATA (bit 3) → next cycle `tx` = 1, `busy` = 0, `get` = 0 during reset. After release, the source restarts and the first word is retransmitted intact.
- `empty` toggled 1→0 during a frame's stop bit → no `get` until the IDLE cycle; the frame timing is unchanged.

Source files
------------

// File: rtl/uart_pull_tx_if.sv
// Pull-source handshake between the transmitter and an upstream ROM/FIFO.
// The transmitter pulses get; the source answers next cycle on data/empty.
interface uart_pull_tx_if #(
    parameter int W = 8
);
    logic         get;
    logic [W-1:0] data;
    logic         empty;

    modport master (output get, input data, input empty);
    modport slave  (input get, output data, output empty);
endinterface

// File: rtl/uart_pull_tx.sv
// Self-paced 8N1-style serial transmitter that pulls words from a sequential
// source until it reports empty. Each bit lasts DIV clocks.
module uart_pull_tx #(
    parameter int W   = 8,
    parameter int DIV = 16
) (
    input  logic            clock,
    input  logic            reset,
    uart_pull_tx_if.master  src,
    output logic            tx,
    output logic            busy
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(W - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [W-1:0]  shift;

    // Pull strobe: one cycle in IDLE whenever the source still has words.
    assign src.get = (state == IDLE) && !reset && !src.empty;

    // Frame sequencer; tx and busy are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src.get) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    // Source output is valid the cycle after get.
                    shift <= src.data;
                    tx    <= 1'b0;
                    cnt   <= CNT_MAX;
                    state <= START;
                end
                START: begin
                    if (cnt == '0) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                        cnt     <= CNT_MAX;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        if (bit_idx == BIT_MAX) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                        cnt <= CNT_MAX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_pull_tx.sv
// Bench for uart_pull_tx: two instances (DIV=4 and DIV=2) fed by pull-style
// ROM sources. A frame-timing model derived from the get times predicts tx,
// busy and get every cycle; a receiver model decodes the DIV=2 line.
module tb_uart_pull_tx;
    localparam int W = 8;
    localparam int DA = 4;
    localparam int DB = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(string tag, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected line level c cycles into a frame whose get was at cycle t.
    function automatic logic exp_tx(longint c, longint t, logic [7:0] w, int div);
        longint o;
        longint s;
        if (t < 0) return 1'b1;
        o = c - t - 2;
        if (o < 0 || o >= longint'((W + 2) * div)) return 1'b1;
        s = o / div;
        if (s == 0) return 1'b0;
        if (s <= W) return w[int'(s) - 1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(longint c, longint t, int div);
        return (t >= 0) && (c >= t + 1) && (c <= t + 1 + longint'((W + 2) * div));
    endfunction

    // ---------------- instance A (DIV=4) ----------------
    logic       reset_a = 1'b1;
    logic       hold_a = 1'b1;
    logic [7:0] rom_a [8];
    int         n_a = 0;
    int         idx_a;
    logic [7:0] out_a;
    logic       src_empty_a;
    logic       tx_a, busy_a;
    uart_pull_tx_if #(.W(W)) ia ();

    assign ia.data  = out_a;
    assign ia.empty = src_empty_a | hold_a;

    always @(posedge clock) begin
        if (reset_a) begin
            idx_a <= 0; out_a <= '0; src_empty_a <= (n_a == 0);
        end else if (ia.get) begin
            out_a <= rom_a[idx_a[2:0]]; idx_a <= idx_a + 1; src_empty_a <= (idx_a + 1 >= n_a);
        end
    end

    uart_pull_tx #(.W(W), .DIV(DA)) dut_a (
        .clock(clock), .reset(reset_a), .src(ia), .tx(tx_a), .busy(busy_a)
    );

    // ---------------- instance B (DIV=2) ----------------
    logic       reset_b = 1'b1;
    logic [7:0] rom_b [8];
    int         n_b = 7;
    int         idx_b;
    logic [7:0] out_b;
    logic       src_empty_b;
    logic       tx_b, busy_b;
    uart_pull_tx_if #(.W(W)) ib ();

    assign ib.data  = out_b;
    assign ib.empty = src_empty_b;

    always @(posedge clock) begin
        if (reset_b) begin
            idx_b <= 0; out_b <= '0; src_empty_b <= (n_b == 0);
        end else if (ib.get) begin
            out_b <= rom_b[idx_b[2:0]]; idx_b <= idx_b + 1; src_empty_b <= (idx_b + 1 >= n_b);
        end
    end

    uart_pull_tx #(.W(W), .DIV(DB)) dut_b (
        .clock(clock), .reset(reset_b), .src(ib), .tx(tx_b), .busy(busy_b)
    );

    // ---------------- models ----------------
    logic       mon = 1'b0;
    longint     gt_a = -1, gt_b = -1;
    logic [7:0] w_a = '0, w_b = '0;
    longint     gq_a[$], gq_b[$];

    // Per-cycle prediction of tx/busy/get from the last get and its word.
    always @(negedge clock) begin
        if (mon) begin
            chk("a_tx", longint'(tx_a), longint'(exp_tx(cyc, gt_a, w_a, DA)));
            chk("a_busy", longint'(busy_a), longint'(exp_busy(cyc, gt_a, DA)));
            chk("a_get", longint'(ia.get),
                longint'(!reset_a && !ia.empty && !exp_busy(cyc, gt_a, DA)));
            if (reset_a) gt_a = -1;
            else if (ia.get) begin gt_a = cyc; w_a = rom_a[idx_a[2:0]]; gq_a.push_back(cyc); end

            chk("b_tx", longint'(tx_b), longint'(exp_tx(cyc, gt_b, w_b, DB)));
            chk("b_busy", longint'(busy_b), longint'(exp_busy(cyc, gt_b, DB)));
            chk("b_get", longint'(ib.get),
                longint'(!reset_b && !ib.empty && !exp_busy(cyc, gt_b, DB)));
            if (reset_b) gt_b = -1;
            else if (ib.get) begin gt_b = cyc; w_b = rom_b[idx_b[2:0]]; gq_b.push_back(cyc); end
        end
    end

    // Line receiver for B: mid-bit sampling from the detected start edge.
    logic       rx_on = 1'b0;
    longint     rx_st = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rxq[$];
    always @(negedge clock) begin
        if (mon && !reset_b) begin
            if (!rx_on) begin
                if (tx_b == 1'b0) begin rx_on = 1'b1; rx_st = cyc; end
            end else begin
                longint o;
                o = cyc - rx_st;
                if (o % DB == DB / 2 && o / DB >= 1 && o / DB <= W)
                    rx_sh = {tx_b, rx_sh[7:1]};
                if (o == longint'((W + 1) * DB + DB / 2)) begin
                    chk("b_stop", longint'(tx_b), 1);
                    rxq.push_back(rx_sh);
                    rx_on = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic wait_cyc(longint target);
        int k = 0;
        while (cyc < target && k < 2000) begin step(); k++; end
    endtask

    task automatic pulse_reset_a();
        reset_a = 1'b1; step(); reset_a = 1'b0;
    endtask

    task automatic wait_gets_a(int target);
        int k = 0;
        while (gq_a.size() < target && k < 600) begin step(); k++; end
        if (gq_a.size() < target) chk("a_get_timeout", longint'(gq_a.size()), longint'(target));
    endtask

    // Waits out the last frame plus margin, then confirms no extra pulls.
    task automatic finish_a(int target);
        wait_gets_a(target);
        if (gq_a.size() > 0) wait_cyc(gq_a[$] + 2 + (W + 2) * DA + 10);
        chk("a_ngets", longint'(gq_a.size()), longint'(target));
    endtask

    task automatic load_a(int n);
        n_a = n;
        for (int i = 0; i < 8; i++) rom_a[i] = 8'($urandom);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int base;
        for (int i = 0; i < 8; i++) rom_b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) rom_a[i] = '0;
        step(); step();
        mon = 1'b1;
        step();
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Idle with empty source: line high, nothing pulled.
        repeat (100) step();
        chk("a_idle_gets", longint'(gq_a.size()), 0);

        // Single word 0x48.
        base = gq_a.size();
        load_a(1); rom_a[0] = 8'h48; hold_a = 1'b0;
        pulse_reset_a();
        finish_a(base + 1);

        // Back-to-back 0x55, 0xA3.
        base = gq_a.size();
        load_a(2); rom_a[0] = 8'h55; rom_a[1] = 8'hA3;
        pulse_reset_a();
        finish_a(base + 2);
        if (gq_a.size() >= base + 2)
            chk("a_b2b_gap", gq_a[base + 1] - gq_a[base], (W + 2) * DA + 2);

        // Reset during data bit 3, then retransmission from the top.
        base = gq_a.size();
        load_a(2);
        pulse_reset_a();
        wait_gets_a(base + 1);
        if (gq_a.size() > base) wait_cyc(gq_a[base] + 2 + 4 * DA + 1);
        pulse_reset_a();
        finish_a(base + 3);

        // Empty released during the stop bit of the first frame.
        base = gq_a.size();
        load_a(2);
        pulse_reset_a();
        wait_gets_a(base + 1);
        hold_a = 1'b1;
        if (gq_a.size() > base) wait_cyc(gq_a[base] + 2 + (W + 1) * DA + 1);
        hold_a = 1'b0;
        finish_a(base + 2);
        if (gq_a.size() >= base + 2)
            chk("a_stop_gap", gq_a[base + 1] - gq_a[base], (W + 2) * DA + 2);

        // Random word counts, data and empty gaps.
        for (int r = 0; r < 4; r++) begin
            base = gq_a.size();
            load_a(int'($urandom_range(1, 4)));
            hold_a = 1'b1;
            pulse_reset_a();
            repeat ($urandom_range(0, 30)) step();
            hold_a = 1'b0;
            finish_a(base + n_a);
        end

        // Seven-word DIV=2 stream, decoded by the receiver.
        wait_cyc(longint'(n_b * ((W + 2) * DB + 2) + 50));
        chk("b_ngets", longint'(gq_b.size()), 7);
        for (int i = 1; i < gq_b.size(); i++)
            chk("b_gap", gq_b[i] - gq_b[i - 1], (W + 2) * DB + 2);
        chk("b_nrx", longint'(rxq.size()), 7);
        for (int i = 0; i < rxq.size() && i < 8; i++)
            chk("b_rx", longint'(rxq[i]), longint'(rom_b[i]));
        chk("b_line_idle", longint'(tx_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
